// File: rtl/opl3_host_reg_writer.sv
// Host-side OPL3 register writer: latches address writes, queues data writes in a small FIFO
// and issues them to the synthesis core paced at least MIN_WR_GAP clocks apart.
// opl3_reg_wr packing: [17] valid, [16] bank_num, [15:8] address, [7:0] data.
module opl3_host_reg_writer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MIN_WR_GAP = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        host_wr,
   input  logic [1:0]  host_addr,
   input  logic [7:0]  host_din,
   output logic [17:0] opl3_reg_wr,
   output logic        fifo_full,
   output logic        busy,
   output logic        overflow,
   input  logic        overflow_clr
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(MIN_WR_GAP + 1);
   localparam logic [CntW-1:0] GapLoad = CntW'(MIN_WR_GAP - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] gap_cnt_q, gap_cnt_d;
   logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]      addr_latch_q, addr_latch_d;
   logic            bank_latch_q, bank_latch_d;
   logic            valid_q, valid_d;
   logic [16:0]     out_q, out_d;
   logic            overflow_q, overflow_d;
   logic [16:0]     mem_q [FIFO_DEPTH];

   logic        empty, full, pop, push, drop, data_wr, addr_wr;
   logic [16:0] head;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

   assign data_wr = host_wr & host_addr[0];
   assign addr_wr = host_wr & ~host_addr[0];
   // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
   assign push    = data_wr & (~full | pop);
   assign drop    = data_wr & full & ~pop;

   always_comb begin
      pop       = 1'b0;
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      unique case (state_q)
         StIdle: pop = ~empty;
         StIssue, StGap: begin
            if (gap_cnt_q == '0) begin
               pop     = ~empty;
               state_d = StIdle;
            end else begin
               state_d   = StGap;
               gap_cnt_d = gap_cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      // The pop edge loads the output register; ISSUE is the cycle valid is high.
      if (pop) begin
         state_d   = StIssue;
         gap_cnt_d = GapLoad;
      end
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q + (PtrW + 1)'(push);
      rd_ptr_d     = rd_ptr_q + (PtrW + 1)'(pop);
      addr_latch_d = addr_wr ? host_din : addr_latch_q;
      bank_latch_d = addr_wr ? host_addr[1] : bank_latch_q;
      valid_d      = pop;
      out_d        = pop ? head : out_q;
      overflow_d   = overflow_q;
      if (overflow_clr) begin
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         gap_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         addr_latch_q <= '0;
         bank_latch_q <= 1'b0;
         valid_q      <= 1'b0;
         out_q        <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_cnt_q    <= gap_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         addr_latch_q <= addr_latch_d;
         bank_latch_q <= bank_latch_d;
         valid_q      <= valid_d;
         out_q        <= out_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PtrW-1:0]] <= {bank_latch_q, addr_latch_q, host_din};
      end
   end

   assign opl3_reg_wr = {valid_q, out_q};
   assign fifo_full   = full;
   assign busy        = (state_q != StIdle) | ~empty;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_opl3_host_reg_writer.sv
// Bench for opl3_host_reg_writer: timestamp-based queue model checked every cycle, a directed
// vector table for latch/latency behaviour, and hand sequences for overflow and reset corners.
module tb_opl3_host_reg_writer;

   localparam int Depth = 4;
   localparam int Gap   = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        host_wr = 1'b0;
   logic [1:0]  host_addr = 2'd0;
   logic [7:0]  host_din = 8'd0;
   logic        overflow_clr = 1'b0;
   logic [17:0] opl3_reg_wr;
   logic        fifo_full, busy, overflow;

   always #5 clk = ~clk;

   opl3_host_reg_writer #(
      .FIFO_DEPTH(Depth),
      .MIN_WR_GAP(Gap)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_wr      (host_wr),
      .host_addr    (host_addr),
      .host_din     (host_din),
      .opl3_reg_wr  (opl3_reg_wr),
      .fifo_full    (fifo_full),
      .busy         (busy),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: an entry issues at max(push edge + 1, previous issue edge + Gap).
   typedef struct packed {
      logic       bank;
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   entry_t     mq[$];
   entry_t     m_out;
   logic       m_valid, m_ovf, m_bank;
   logic [7:0] m_addr;
   longint     edge_n, last_iss;
   bit         has_iss;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_out    = '0;
         m_valid  = 1'b0;
         m_ovf    = 1'b0;
         m_bank   = 1'b0;
         m_addr   = 8'h00;
         edge_n   = 0;
         last_iss = 0;
         has_iss  = 1'b0;
      end else begin
         bit pop, drop;
         edge_n++;
         pop  = (mq.size() != 0) && (!has_iss || edge_n >= last_iss + Gap);
         drop = 1'b0;
         m_valid = pop;
         if (pop) begin
            m_out    = mq.pop_front();
            last_iss = edge_n;
            has_iss  = 1'b1;
         end
         if (host_wr) begin
            if (host_addr[0]) begin
               if (mq.size() < Depth) mq.push_back(entry_t'({m_bank, m_addr, host_din}));
               else drop = 1'b1;
            end else begin
               m_addr = host_din;
               m_bank = host_addr[1];
            end
         end
         if (overflow_clr) m_ovf = 1'b0;
         else if (drop) m_ovf = 1'b1;
      end
   end

   bit          mon_en = 1'b0;
   longint      neg_n = 0;
   int          n_pulses = 0;
   longint      pulse_t[$];
   logic [16:0] pulse_v[$];

   always @(negedge clk) begin
      neg_n++;
      if (rst_n && mon_en) begin
         logic exp_busy;
         exp_busy = (mq.size() != 0) || (has_iss && edge_n < last_iss + Gap);
         check("cycle", 32'({opl3_reg_wr, fifo_full, busy, overflow}),
               32'({m_valid, m_out, (mq.size() == Depth), exp_busy, m_ovf}));
         if (opl3_reg_wr[17]) begin
            n_pulses++;
            pulse_t.push_back(neg_n);
            pulse_v.push_back(opl3_reg_wr[16:0]);
         end
      end
   end

   task automatic wr(input logic [1:0] port, input logic [7:0] din, input logic clr = 1'b0);
      host_wr      = 1'b1;
      host_addr    = port;
      host_din     = din;
      overflow_clr = clr;
      @(negedge clk);
      host_wr      = 1'b0;
      overflow_clr = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int i = 0;
      while (busy && i < limit) begin
         @(negedge clk);
         i++;
      end
      check("wait_idle", 32'(busy), 32'(0));
   endtask

   task automatic wait_valid(input int limit);
      int i = 0;
      while (!opl3_reg_wr[17] && i < limit) begin
         @(negedge clk);
         i++;
      end
      check("wait_valid", 32'(opl3_reg_wr[17]), 32'(1));
   endtask

   typedef struct {
      logic       do_addr;
      logic [1:0] aport;
      logic [7:0] a;
      logic [1:0] dport;
      logic [7:0] d;
      logic       eb;
      logic [7:0] ea;
   } vec_t;

   initial begin
      vec_t       vt[5];
      int         p0, t0, rate;
      logic [7:0] dv;

      vt[0] = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h5A, 1'b0, 8'h00};
      vt[1] = '{1'b1, 2'd0, 8'hBD, 2'd1, 8'h20, 1'b0, 8'hBD};
      vt[2] = '{1'b1, 2'd2, 8'h05, 2'd3, 8'h01, 1'b1, 8'h05};
      vt[3] = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h77, 1'b1, 8'h05};
      vt[4] = '{1'b1, 2'd0, 8'h40, 2'd3, 8'h3C, 1'b0, 8'h40};

      #3 rst_n = 1'b0;
      #1;
      check("rst_out", 32'(opl3_reg_wr), 32'(0));
      check("rst_flags", 32'({fifo_full, busy, overflow}), 32'(0));
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Latch behaviour and strobe-to-valid latency.
      for (int k = 0; k < 5; k++) begin
         if (vt[k].do_addr) wr(vt[k].aport, vt[k].a);
         wr(vt[k].dport, vt[k].d);
         check("lat1_valid", 32'(opl3_reg_wr[17]), 32'(0));
         @(negedge clk);
         check("lat2_wr", 32'(opl3_reg_wr), 32'({1'b1, vt[k].eb, vt[k].ea, vt[k].d}));
         wait_idle(Gap + 4);
      end

      // Five back-to-back writes: first pop frees a slot, so all five issue in order.
      p0 = n_pulses;
      t0 = pulse_t.size();
      wr(2'd0, 8'hC0);
      for (int i = 0; i < 5; i++) wr(2'd1, 8'h11 + 8'(i));
      check("burst_ovf", 32'(overflow), 32'(0));
      wait_idle(6 * Gap);
      check("burst_count", 32'(n_pulses - p0), 32'(5));
      for (int i = 1; i < 5; i++)
         check("burst_gap", 32'(pulse_t[t0 + i] - pulse_t[t0 + i - 1]), 32'(Gap));
      for (int i = 0; i < 5; i++) begin
         dv = 8'h11 + 8'(i);
         check("burst_order", 32'(pulse_v[t0 + i]), 32'({1'b0, 8'hC0, dv}));
      end

      // Write while full, coincident with the pop at gap expiry.
      p0 = n_pulses;
      wr(2'd1, 8'hA0);
      wait_valid(4);
      for (int i = 0; i < 4; i++) wr(2'd1, 8'hA1 + 8'(i));
      check("full_before_pop", 32'(fifo_full), 32'(1));
      repeat (Gap - 5) @(negedge clk);
      wr(2'd1, 8'hA5);
      check("coinc_valid", 32'(opl3_reg_wr[17]), 32'(1));
      check("coinc_full", 32'(fifo_full), 32'(1));
      check("coinc_ovf", 32'(overflow), 32'(0));
      wait_idle(6 * Gap);
      check("coinc_count", 32'(n_pulses - p0), 32'(6));

      // Drop sets overflow; clear together with another drop wins.
      p0 = n_pulses;
      wr(2'd1, 8'hB0);
      wait_valid(4);
      for (int i = 0; i < 4; i++) wr(2'd1, 8'hB1 + 8'(i));
      wr(2'd1, 8'hBF);
      check("ovf_set", 32'(overflow), 32'(1));
      wr(2'd1, 8'hBE, 1'b1);
      check("ovf_clr_wins", 32'(overflow), 32'(0));
      check("ovf_still_full", 32'(fifo_full), 32'(1));
      wait_idle(6 * Gap);
      check("ovf_count", 32'(n_pulses - p0), 32'(5));

      // Reset mid-GAP with entries queued.
      wr(2'd2, 8'h99);
      for (int i = 0; i < 3; i++) wr(2'd1, 8'h60 + 8'(i));
      repeat (5) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out", 32'(opl3_reg_wr), 32'(0));
      check("mid_rst_flags", 32'({fifo_full, busy, overflow}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      p0 = n_pulses;
      repeat (4 * Gap) @(negedge clk);
      check("rst_no_pulse", 32'(n_pulses - p0), 32'(0));
      check("rst_idle", 32'({busy, overflow}), 32'(0));
      wr(2'd1, 8'h42);
      @(negedge clk);
      check("post_rst_wr", 32'(opl3_reg_wr), 32'({1'b1, 1'b0, 8'h00, 8'h42}));
      wait_idle(Gap + 4);

      // Random traffic, alternating light and heavy load.
      for (int blk = 0; blk < 8; blk++) begin
         rate = (blk % 2 == 1) ? 70 : 8;
         for (int c = 0; c < 300; c++) begin
            host_wr      = ($urandom_range(0, 99) < rate);
            host_addr    = 2'($urandom_range(0, 3));
            host_din     = 8'($urandom);
            overflow_clr = ($urandom_range(0, 99) < 3);
            @(negedge clk);
         end
      end
      host_wr      = 1'b0;
      overflow_clr = 1'b0;
      wait_idle((Depth + 2) * Gap);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
